if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
Instruction-fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline register (drives its addr_i/inst_i).
- Generates sequential PCs and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Holds its output while the hazard unit stalls, buffering the in-flight response in a 1-entry skid.
- Squashes and refetches on a branch/jump redirect from ID.

Parameters:
ADDR_W, 32, PC/address width
INST_W, 32, instruction width
RESET_PC, 0, PC after reset
NOP_INST, 0, instruction driven when output is invalid or flushed

Ports:
Clk  in  1  clock, all state updates on posedge
Rst  in  1  synchronous reset, active-high
Start  in  1  level; fetch issues only while high
stall_i  in  1  hazard unit: IF/ID must hold, no new fetch
redirect_i  in  1  taken branch/jump from ID: flush and refetch
redirect_pc_i  in  ADDR_W  target PC for redirect
imem_req_o  out  1  read request this cycle (combinational)
imem_addr_o  out  ADDR_W  read address (= pc_q)
imem_data_i  in  INST_W  read data, valid the cycle after imem_req_o
addr_o  out  ADDR_W  PC of presented instruction (to IF/ID addr_i)
inst_o  out  INST_W  presented instruction (to IF/ID inst_i)
valid_o  out  1  addr_o/inst_o hold a real instruction

Behaviour:
- Reset (Rst=1 at posedge, any state, mid-operation included):
  - pc_q=RESET_PC; inflight_q=0; skid empty.
  - valid_o=0, addr_o=0, inst_o=NOP_INST; FSM->IDLE.
- imem_req_o is 0 in the reset cycle.
- FSM IDLE/RUN:
  - IDLE->RUN at posedge with Start=1; RUN->IDLE at posedge with Start=0.
  - issue = (state==RUN) && Start && !stall_i && !redirect_i.
- imem_req_o=issue; imem_addr_o=pc_q.
- On issue: pc_q<=pc_q+4 (mod 2^ADDR_W, wraps silently); inflight_q<=1, inflight_addr_q<=pc_q. Otherwise inflight_q<=0.
- Response present in a cycle iff inflight_q=1; data = imem_data_i, addr = inflight_addr_q.
- Output update, priority Rst > redirect_i > stall_i:
  - redirect_i=1:
    - pc_q<=redirect_pc_i.
    - Current response discarded; skid cleared.
    - valid_o<=0, inst_o<=NOP_INST, addr_o held.
    - No issue this cycle; target requested next cycle if not stalled.
  - stall_i=1: addr_o/inst_o/valid_o hold. If response present, it is written to the skid.
  - neither, in order:
    - skid full: output<=skid, skid cleared.
    - else response present: output<=response, valid_o<=1.
    - else valid_o<=0, inst_o<=NOP_INST.
  - A response arriving while the skid drains cannot occur: no issue happens while stalled.
- Skid depth 1 is sufficient. Skid write while skid full is an invariant violation; flag with an assertion.
- Latency:
  - Start high from IDLE: posedge 1 enters RUN.
  - Cycle 1 issues RESET_PC.
  - posedge 3: valid_o=1 with addr_o=RESET_PC.
  - Steady state: one instruction per cycle.
- Start falling mid-stream: no new issue; in-flight response still delivered; pc_q holds and resumes on the next Start.
- Order is strictly by PC; no instruction is duplicated or dropped except by a redirect flush.

Decomposition:
- Package if_pkg: NOP_INST default, PC_STEP=4, FSM state enum {IDLE,RUN}, pc_next function (pc+PC_STEP).
- One sub-module, fetch_skid: 1-entry buffer with ports wr_en, wr_addr, wr_inst, rd_en, clr, full, rd_addr, rd_inst. Synchronous clear shares Rst and redirect.

Test Plan:
- Imem model: inst at A = 0xA000_0000|A.
- Reset then Start=1 for 6 cycles, no stall -> valid_o rises at posedge 3. addr_o sequence is 0,4,8,12; inst_o is 0xA0000000, 0xA0000004, ...
- Steady stream, stall_i=1 for 3 cycles while addr_o=4 -> outputs hold 4/0xA0000004. Skid captures addr 8. After release: 8, then 12 on consecutive cycles; no gaps, no duplicates.
- Redirect_i=1 with redirect_pc_i=0x40 while addr_o=8 -> next cycle valid_o=0, inst_o=0. Addr 12's response is dropped. valid_o=1 at addr 0x40 two cycles later.
- Redirect and stall asserted together with the skid full -> skid cleared, valid_o=0. The first valid output is 0x40 after stall drops.
- Rst asserted mid-stream with skid full -> next cycle valid_o=0, inst_o=0, imem_req_o=0. Restart fetches from RESET_PC.
- RESET_PC=0xFFFF_FFF8, run 4 instructions -> addr_o sequence is FFFFFFF8, FFFFFFFC, 0, 4 (wrap).

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  // Instruction presented when nothing valid is on the output.
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_STEP = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Sequential successor of a PC.  Works on a 64-bit value so that any
  // ADDR_W up to 64 can use it.  The caller truncates the result, which
  // gives the silent modulo-2^ADDR_W wrap.
  function automatic logic [63:0] pc_next(input logic [63:0] pc);
    return pc + 64'(PC_STEP);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory port: the fetch stage drives the request and
// address, and the memory returns data one cycle later.
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [INST_W-1:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_data_i
  );
endinterface

// File: rtl/if_fetch_skid.sv
// One-entry skid buffer.  It holds the memory response that lands while
// the pipeline is stalled.  clr has priority over everything else.
module fetch_skid #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_inst,
  input  logic              rd_en,
  output logic              full,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_inst
);

  logic              r_full;
  logic [ADDR_W-1:0] r_addr;
  logic [INST_W-1:0] r_inst;

  // Occupancy flag: a clear empties the buffer, a write fills it, and a
  // read drains it.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_full <= 1'b0;
    end else if (wr_en) begin
      r_full <= 1'b1;
    end else if (rd_en) begin
      r_full <= 1'b0;
    end
  end

  // Payload capture.  The payload needs no reset because it is qualified by r_full.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      r_addr <= wr_addr;
      r_inst <= wr_inst;
    end
  end

  assign full    = r_full;
  assign rd_addr = r_addr;
  assign rd_inst = r_inst;

  // Only one response can be in flight when a stall begins, so a second
  // write into a full buffer means the upstream issue logic is broken.
  a_no_overwrite: assert property (@(posedge clk) disable iff (clr) !(wr_en && r_full));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage.  It generates sequential PCs, reads from a
// 1-cycle-latency imem, and presents the PC/instruction pair to IF/ID.
// Stall and redirect from later stages are honoured.
module if_fetch
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  if_fetch_if.master        imem,
  output logic [ADDR_W-1:0] addr_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic              w_issue;

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_addr;

  logic [ADDR_W-1:0] r_addr;
  logic [INST_W-1:0] r_inst;
  logic              r_valid;

  logic              w_skid_clr;
  logic              w_skid_wr;
  logic              w_skid_rd;
  logic              w_skid_full;
  logic [ADDR_W-1:0] w_skid_addr;
  logic [INST_W-1:0] w_skid_inst;

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: Start alone moves the stage between IDLE and RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (Start)  w_state_next = RUN;
      RUN:     if (!Start) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM output: issue a read only while running and not held back.
  always_comb begin
    w_issue = 1'b0;
    if (r_state == RUN && Start && !stall_i && !redirect_i && !Rst) begin
      w_issue = 1'b1;
    end
  end

  assign imem.imem_req_o  = w_issue;
  assign imem.imem_addr_o = r_pc;

  // PC and in-flight tracking.  A redirect overrides the sequential PC.
  // Each issue records the address whose data returns next cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (redirect_i) begin
        r_pc <= redirect_pc_i;
      end else if (w_issue) begin
        r_pc            <= ADDR_W'(pc_next(64'(r_pc)));
        r_inflight_addr <= r_pc;
      end
    end
  end

  // The skid catches a response that arrives during a stall.  The skid
  // drains first once the stall lifts.  A redirect flushes it.
  assign w_skid_clr = Rst || redirect_i;
  assign w_skid_wr  = r_inflight && stall_i && !redirect_i && !Rst;
  assign w_skid_rd  = w_skid_full && !stall_i && !redirect_i && !Rst;

  fetch_skid #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk     (Clk),
    .clr     (w_skid_clr),
    .wr_en   (w_skid_wr),
    .wr_addr (r_inflight_addr),
    .wr_inst (imem.imem_data_i),
    .rd_en   (w_skid_rd),
    .full    (w_skid_full),
    .rd_addr (w_skid_addr),
    .rd_inst (w_skid_inst)
  );

  // Output register feeding IF/ID.  Priority is reset, then redirect,
  // then stall.  Skid contents are older than a live response, so they
  // go out first.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_inst  <= NOP_INST;
    end else if (redirect_i) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end else if (!stall_i) begin
      if (w_skid_full) begin
        r_valid <= 1'b1;
        r_addr  <= w_skid_addr;
        r_inst  <= w_skid_inst;
      end else if (r_inflight) begin
        r_valid <= 1'b1;
        r_addr  <= r_inflight_addr;
        r_inst  <= imem.imem_data_i;
      end else begin
        r_valid <= 1'b0;
        r_inst  <= NOP_INST;
      end
    end
  end

  assign addr_o  = r_addr;
  assign inst_o  = r_inst;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch.  It runs two instances, one with RESET_PC=0 and
// one with RESET_PC=0xFFFFFFF8 so the PC wrap is exercised.  The same
// directed and random stimulus drives both.  The reference model is a
// queue of pending fetch addresses.
module tb_if_fetch;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
  } stim_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;

  logic [31:0] addr_o [2];
  logic [31:0] inst_o [2];
  logic        valid_o [2];

  if_fetch_if #(.ADDR_W(32), .INST_W(32)) imem0 ();
  if_fetch_if #(.ADDR_W(32), .INST_W(32)) imem1 ();

  if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000), .NOP_INST(32'h0)) dut0 (
    .Clk(clk), .Rst(Rst), .Start(Start), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem(imem0),
    .addr_o(addr_o[0]), .inst_o(inst_o[0]), .valid_o(valid_o[0])
  );

  if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INST(32'h0)) dut1 (
    .Clk(clk), .Rst(Rst), .Start(Start), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem(imem1),
    .addr_o(addr_o[1]), .inst_o(inst_o[1]), .valid_o(valid_o[1])
  );

  // Imem models: the data at A is 0xA0000000|A, returned one cycle after
  // the request.  Cycles without a request return garbage.
  always @(posedge clk) begin
    imem0.imem_data_i <= imem0.imem_req_o ? (32'hA000_0000 | imem0.imem_addr_o) : $urandom;
    imem1.imem_data_i <= imem1.imem_req_o ? (32'hA000_0000 | imem1.imem_addr_o) : $urandom;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [31:0] RST_PC [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  logic [31:0] m_pc [2];
  logic [31:0] m_a  [2];
  logic [31:0] m_i  [2];
  bit          m_v  [2];
  bit          m_run [2];
  bit          m_init [2] = '{1'b0, 1'b0};
  logic [31:0] m_q0 [$];
  logic [31:0] m_q1 [$];

  function automatic void q_clear(input int k);
    if (k == 0) m_q0.delete(); else m_q1.delete();
  endfunction
  function automatic void q_push(input int k, input logic [31:0] a);
    if (k == 0) m_q0.push_back(a); else m_q1.push_back(a);
  endfunction
  function automatic int q_size(input int k);
    return (k == 0) ? m_q0.size() : m_q1.size();
  endfunction
  function automatic logic [31:0] q_pop(input int k);
    if (k == 0) return m_q0.pop_front();
    return m_q1.pop_front();
  endfunction

  function automatic bit m_issue(input int k, input stim_t s);
    return !s.rst && m_run[k] && s.start && !s.stall && !s.redir;
  endfunction

  // Model one clock edge.  Fetched addresses are queued in PC order and
  // delivered oldest-first whenever IF/ID is free.  A redirect throws
  // away everything pending.
  function automatic void model_step(input int k, input stim_t s);
    bit iss;
    if (s.rst) begin
      m_pc[k] = RST_PC[k]; m_run[k] = 1'b0; q_clear(k);
      m_v[k] = 1'b0; m_a[k] = '0; m_i[k] = '0; m_init[k] = 1'b1;
    end else begin
      iss = m_issue(k, s);
      if (s.redir) begin
        q_clear(k); m_v[k] = 1'b0; m_i[k] = '0;
      end else if (!s.stall) begin
        if (q_size(k) > 0) begin
          m_a[k] = q_pop(k); m_i[k] = 32'hA000_0000 | m_a[k]; m_v[k] = 1'b1;
        end else begin
          m_v[k] = 1'b0; m_i[k] = '0;
        end
      end
      if (s.redir) m_pc[k] = s.rpc;
      else if (iss) begin
        q_push(k, m_pc[k]); m_pc[k] = m_pc[k] + 32'd4;
      end
      m_run[k] = s.start;
    end
  endfunction

  // Run one clock cycle.  The combinational request is checked mid-cycle
  // and the registered outputs are checked just after the edge.
  task automatic run_cycle(input stim_t s);
    logic req_k;
    logic [31:0] addr_k;
    Rst = s.rst; Start = s.start; stall_i = s.stall;
    redirect_i = s.redir; redirect_pc_i = s.rpc;
    #2;
    for (int k = 0; k < 2; k++) begin
      req_k  = (k == 0) ? imem0.imem_req_o  : imem1.imem_req_o;
      addr_k = (k == 0) ? imem0.imem_addr_o : imem1.imem_addr_o;
      check_eq("imem_req", {63'd0, req_k}, {63'd0, m_issue(k, s)});
      if (m_init[k]) check_eq("imem_addr", {32'd0, addr_k}, {32'd0, m_pc[k]});
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_step(k, s);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("valid_o", {63'd0, valid_o[k]}, {63'd0, m_v[k]});
      check_eq("addr_o",  {32'd0, addr_o[k]},  {32'd0, m_a[k]});
      check_eq("inst_o",  {32'd0, inst_o[k]},  {32'd0, m_i[k]});
    end
    $display("cyc %0d rst=%0b start=%0b stall=%0b redir=%0b | dut0 v=%0b a=%h i=%h | dut1 v=%0b a=%h i=%h",
             cyc, s.rst, s.start, s.stall, s.redir,
             valid_o[0], addr_o[0], inst_o[0], valid_o[1], addr_o[1], inst_o[1]);
  endtask

  function automatic stim_t mk(input bit rst, input bit start, input bit stall,
                               input bit redir, input logic [31:0] rpc);
    stim_t s;
    s.rst = rst; s.start = start; s.stall = stall; s.redir = redir; s.rpc = rpc;
    return s;
  endfunction

  initial begin
    stim_t s;
    // Reset.
    run_cycle(mk(1, 0, 0, 0, 0));
    run_cycle(mk(1, 0, 0, 0, 0));
    check_eq("reset_valid", {63'd0, valid_o[0]}, 64'd0);
    check_eq("reset_addr",  {32'd0, addr_o[0]},  64'd0);
    check_eq("reset_inst",  {32'd0, inst_o[0]},  64'd0);

    // Start: the first valid output appears at the third posedge.
    run_cycle(mk(0, 1, 0, 0, 0));
    run_cycle(mk(0, 1, 0, 0, 0));
    check_eq("lat_not_yet", {63'd0, valid_o[0]}, 64'd0);
    run_cycle(mk(0, 1, 0, 0, 0));
    check_eq("lat_valid",   {63'd0, valid_o[0]}, 64'd1);
    check_eq("lat_addr0",   {32'd0, addr_o[0]},  64'h0);
    check_eq("lat_inst0",   {32'd0, inst_o[0]},  64'hA000_0000);
    check_eq("wrap_first",  {32'd0, addr_o[1]},  64'hFFFF_FFF8);
    run_cycle(mk(0, 1, 0, 0, 0));
    check_eq("seq_addr4",   {32'd0, addr_o[0]},  64'h4);
    check_eq("wrap_second", {32'd0, addr_o[1]},  64'hFFFF_FFFC);

    // Stall for three cycles while addr 4 is presented.
    for (int i = 0; i < 3; i++) run_cycle(mk(0, 1, 1, 0, 0));
    check_eq("stall_hold_a", {32'd0, addr_o[0]}, 64'h4);
    check_eq("stall_hold_i", {32'd0, inst_o[0]}, 64'hA000_0004);
    run_cycle(mk(0, 1, 0, 0, 0));
    check_eq("skid_drain",  {32'd0, addr_o[0]},  64'h8);
    check_eq("wrap_zero",   {32'd0, addr_o[1]},  64'h0);

    // Redirect to 0x40 while addr 8 is presented.
    run_cycle(mk(0, 1, 0, 1, 32'h40));
    check_eq("redir_valid", {63'd0, valid_o[0]}, 64'd0);
    check_eq("redir_inst",  {32'd0, inst_o[0]},  64'd0);
    run_cycle(mk(0, 1, 0, 0, 0));
    run_cycle(mk(0, 1, 0, 0, 0));
    check_eq("redir_target", {32'd0, addr_o[0]}, 64'h40);

    // Redirect together with stall while the skid is full.
    run_cycle(mk(0, 1, 0, 0, 0));
    run_cycle(mk(0, 1, 1, 0, 0));
    run_cycle(mk(0, 1, 1, 1, 32'h40));
    check_eq("rs_valid", {63'd0, valid_o[0]}, 64'd0);
    run_cycle(mk(0, 1, 1, 0, 0));
    run_cycle(mk(0, 1, 0, 0, 0));
    run_cycle(mk(0, 1, 0, 0, 0));
    check_eq("rs_first", {32'd0, addr_o[0]}, 64'h40);
    run_cycle(mk(0, 1, 0, 0, 0));

    // Reset in mid-stream with the skid full, then restart.
    run_cycle(mk(0, 1, 1, 0, 0));
    run_cycle(mk(1, 1, 1, 0, 0));
    check_eq("mrst_valid", {63'd0, valid_o[0]}, 64'd0);
    check_eq("mrst_inst",  {32'd0, inst_o[0]},  64'd0);
    for (int i = 0; i < 3; i++) run_cycle(mk(0, 1, 0, 0, 0));
    check_eq("mrst_restart", {32'd0, addr_o[0]}, 64'h0);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 99) < 3);
      s.start = ($urandom_range(0, 99) < 88);
      s.stall = ($urandom_range(0, 99) < 25);
      s.redir = ($urandom_range(0, 99) < 10);
      s.rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      run_cycle(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
